// File: rtl/coder_deinterleaver.sv
// coder_deinterleaver: bit-serial QPP deinterleaver (inverse of the coder interleaver).
// Loads one interleaved block of K bits (1056 or 6144) into a 6144 x 1 buffer at
// natural-order addresses pi(i), then streams the block out in natural order.
// Optional feature macro: CODER_DEINT_LAST_EN adds in_last / out_last / err_len.
module coder_deinterleaver #(
  parameter int K_SMALL = 1056,
  parameter int K_LARGE = 6144,
  parameter int AW      = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic K_eq_6144,
  input  logic in_valid,
  input  logic in_data,
  output logic in_ready,
  output logic out_valid,
  output logic out_data,
  input  logic out_ready,
  output logic busy
`ifdef CODER_DEINT_LAST_EN
  ,
  input  logic in_last,
  output logic out_last,
  output logic err_len
`endif
);

  // QPP coefficients and the seeds of the recursive address generator
  localparam int F1_S = 17;
  localparam int F2_S = 66;
  localparam int F1_L = 263;
  localparam int F2_L = 480;
  localparam logic [AW-1:0] KS     = AW'(K_SMALL);
  localparam logic [AW-1:0] KL     = AW'(K_LARGE);
  localparam logic [AW-1:0] G0_S   = AW'((F1_S + F2_S) % K_SMALL);
  localparam logic [AW-1:0] STEP_S = AW'((2 * F2_S) % K_SMALL);
  localparam logic [AW-1:0] G0_L   = AW'((F1_L + F2_L) % K_LARGE);
  localparam logic [AW-1:0] STEP_L = AW'((2 * F2_L) % K_LARGE);

  typedef enum logic [1:0] {LOAD, TURN, DRAIN} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   cnt_reg, cnt_next;
  logic [AW-1:0]   pi_reg, pi_next;
  logic [AW-1:0]   g_reg, g_next;
  logic            ksel_reg, ksel_next;
  logic            busy_reg, busy_next;
  logic            out_valid_reg, out_valid_next;
  logic            out_data_reg;
  logic            wr_en, rd_en, accept, first_bit, k_sel_eff;
  logic [AW-1:0]   k_cur, g_cur, step_cur;

  logic mem [0:K_LARGE-1];

  // (a + b) mod m with a, b < m: one conditional subtract
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                            input logic [AW-1:0] m);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[AW-1:0];
  endfunction

  // ready only in LOAD and never while reset is asserted
  assign in_ready  = (state_reg == LOAD) && !rst;
  assign accept    = in_valid && in_ready;
  assign first_bit = (cnt_reg == '0);
  // the size select is taken live on the first bit, from the latch afterwards
  assign k_sel_eff = (state_reg == LOAD && first_bit) ? K_eq_6144 : ksel_reg;
  assign k_cur     = k_sel_eff ? KL : KS;
  assign step_cur  = k_sel_eff ? STEP_L : STEP_S;
  assign g_cur     = first_bit ? (k_sel_eff ? G0_L : G0_S) : g_reg;

  // next-state, address generation and handshake control
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    pi_next        = pi_reg;
    g_next         = g_reg;
    ksel_next      = ksel_reg;
    busy_next      = busy_reg;
    out_valid_next = out_valid_reg;
    wr_en          = 1'b0;
    rd_en          = 1'b0;
    case (state_reg)
      LOAD: begin
        if (accept) begin
          wr_en     = 1'b1;
          busy_next = 1'b1;
          if (first_bit) ksel_next = K_eq_6144;
          pi_next = mod_add(pi_reg, g_cur, k_cur);
          g_next  = mod_add(g_cur, step_cur, k_cur);
          if (cnt_reg == k_cur - AW'(1)) begin
            cnt_next   = '0;
            state_next = TURN;
          end else begin
            cnt_next = cnt_reg + AW'(1);
          end
        end
      end
      TURN: begin
        rd_en          = 1'b1;
        cnt_next       = AW'(1);
        out_valid_next = 1'b1;
        state_next     = DRAIN;
      end
      DRAIN: begin
        // cnt_reg is the next read address; cnt_reg == K means j = K-1 is on the output
        if (!out_valid_reg || out_ready) begin
          if (cnt_reg == k_cur) begin
            if (out_valid_reg) begin
              cnt_next       = '0;
              pi_next        = '0;
              g_next         = '0;
              busy_next      = 1'b0;
              out_valid_next = 1'b0;
              state_next     = LOAD;
            end
          end else begin
            rd_en          = 1'b1;
            cnt_next       = cnt_reg + AW'(1);
            out_valid_next = 1'b1;
          end
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= LOAD;
      cnt_reg       <= '0;
      pi_reg        <= '0;
      g_reg         <= '0;
      ksel_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pi_reg        <= pi_next;
      g_reg         <= g_next;
      ksel_reg      <= ksel_next;
      busy_reg      <= busy_next;
      out_valid_reg <= out_valid_next;
    end
  end

  // buffer write port; contents are never cleared since each block rewrites every location
  always_ff @(posedge clk) begin
    if (wr_en) mem[pi_reg] <= in_data;
  end

  // synchronous read doubles as the one-entry output register
  always_ff @(posedge clk) begin
    if (rst)        out_data_reg <= 1'b0;
    else if (rd_en) out_data_reg <= mem[cnt_reg];
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign busy      = busy_reg;

`ifdef CODER_DEINT_LAST_EN
  logic err_len_reg;

  // sticky length error: in_last on any bit other than the K-th
  always_ff @(posedge clk) begin
    if (rst) err_len_reg <= 1'b0;
    else if (accept && in_last && (cnt_reg != k_cur - AW'(1))) err_len_reg <= 1'b1;
  end

  assign out_last = out_valid_reg && (state_reg == DRAIN) && (cnt_reg == k_cur);
  assign err_len  = err_len_reg;
`endif

endmodule

// File: tb/tb_coder_deinterleaver.sv
// tb_coder_deinterleaver: directed bench for coder_deinterleaver.
// Optional feature macro: CODER_DEINT_LAST_EN (enables in_last/out_last/err_len checks).
module tb_coder_deinterleaver;

  localparam int LIMIT = 30000;

  logic clk = 1'b0;
  logic rst, K_eq_6144, in_valid, in_data, in_ready, out_valid, out_data, out_ready, busy;
`ifdef CODER_DEINT_LAST_EN
  logic in_last, out_last, err_len;
`endif

  int tests = 0;
  int fails = 0;

  bit orig [0:6143];
  bit src  [0:6143];
  bit rcv  [0:6143];
  bit ref1 [0:6143];

  coder_deinterleaver dut (
    .clk(clk), .rst(rst), .K_eq_6144(K_eq_6144),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy)
`ifdef CODER_DEINT_LAST_EN
    , .in_last(in_last), .out_last(out_last), .err_len(err_len)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // direct closed-form QPP permutation, independent of the recursive generator
  function automatic int pi_of(input int k, input int i);
    longint f1, f2;
    f1 = (k == 6144) ? 263 : 17;
    f2 = (k == 6144) ? 480 : 66;
    return int'((f1 * longint'(i) + f2 * longint'(i) * longint'(i)) % longint'(k));
  endfunction

  // interleaver model: arrival bit i carries natural bit pi(i)
  task automatic interleave(input int k);
    for (int i = 0; i < k; i++) src[i] = orig[pi_of(k, i)];
  endtask

  task automatic send_block(input int k, input bit kbit, input bit bubbles,
                            input int flip_at, input int last_at);
    int i = 0;
    int n = 0;
    bit acc;
    while (i < k && n < LIMIT) begin
      @(negedge clk);
      in_valid  = bubbles ? ($urandom_range(0, 99) < 50) : 1'b1;
      in_data   = src[i];
      K_eq_6144 = (i >= flip_at) ? ~kbit : kbit;
`ifdef CODER_DEINT_LAST_EN
      in_last   = (i == last_at);
`endif
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) i++;
      n++;
    end
    check("load_count", i, k);
    // this negedge is the TURN cycle: keep valid high to show it is refused
    @(negedge clk);
    check("turn_in_ready", in_ready, 0);
    check("turn_out_valid", out_valid, 0);
    in_valid = 1'b0;
`ifdef CODER_DEINT_LAST_EN
    in_last  = 1'b0;
`endif
    if (last_at < 0) check("last_at_unused", 0, 0 & last_at);
  endtask

  task automatic recv_block(input int k, input bit stall);
    int  j = 0;
    int  n = 1;
    int  first_lat = -1;
    int  unstable = 0;
    int  last_bad = 0;
    bit  pv = 0, pr = 0, pd = 0;
    bit  take;
    while (j < k && n < LIMIT) begin
      @(negedge clk);
      n++;
      out_ready = stall ? ($urandom_range(0, 99) < 50) : 1'b1;
      if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd)) unstable++;
      if (out_valid && first_lat < 0) begin
        first_lat = n;
        check("busy_drain", busy, 1);
      end
      take = out_valid && out_ready;
`ifdef CODER_DEINT_LAST_EN
      if (out_valid && (out_last !== (j == k - 1))) last_bad++;
`endif
      if (take) begin
        rcv[j] = out_data;
        j++;
      end
      pv = out_valid; pr = out_ready; pd = out_data;
      @(posedge clk);
    end
    check("drain_count", j, k);
    check("first_valid_latency", first_lat, 2);
    check("stall_stable", unstable, 0);
    check("out_last_flag", last_bad, 0);
    if (!stall) check("last_handshake_cycle", n, k + 1);
    @(negedge clk);
    out_ready = 1'b0;
    check("reload_in_ready", in_ready, 1);
    check("end_out_valid", out_valid, 0);
    check("end_busy", busy, 0);
    $display("[TB] block K=%0d stall=%0d drained in %0d cycles", k, stall, n);
  endtask

  task automatic compare(input string tag, input int k);
    int bad = 0;
    for (int j = 0; j < k; j++) if (rcv[j] != orig[j]) bad++;
    check(tag, bad, 0);
  endtask

  // one input bit set at arrival i_pos; the lone 1 must appear at exp_j
  task automatic single_one(input int k, input bit kbit, input int i_pos, input int exp_j);
    int ones = 0;
    int pos = -1;
    for (int i = 0; i < k; i++) src[i] = (i == i_pos);
    send_block(k, kbit, 1'b0, 99999, k - 1);
    recv_block(k, 1'b0);
    for (int j = 0; j < k; j++) if (rcv[j]) begin ones++; pos = j; end
    check("single_one_count", ones, 1);
    check("single_one_pos", pos, exp_j);
  endtask

  initial begin
    rst = 1'b1; K_eq_6144 = 1'b0; in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b0;
`ifdef CODER_DEINT_LAST_EN
    in_last = 1'b0;
`endif
    // reset held for three cycles
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
    end
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // K = 1056 single one and K = 6144 address check
    single_one(1056, 1'b0, 1, 83);
    single_one(6144, 1'b1, 1, 743);
    single_one(6144, 1'b1, 2, 2446);
    single_one(6144, 1'b1, 3, 5109);

    // round trip through the interleaver model, both sizes
    for (int i = 0; i < 6144; i++) orig[i] = 1'($urandom);
    interleave(6144);
    send_block(6144, 1'b1, 1'b0, 99999, 6143);
    recv_block(6144, 1'b0);
    compare("roundtrip_6144", 6144);

    for (int i = 0; i < 1056; i++) begin orig[i] = 1'($urandom); ref1[i] = orig[i]; end
    interleave(1056);
    send_block(1056, 1'b0, 1'b0, 99999, 1055);
    recv_block(1056, 1'b0);
    compare("roundtrip_1056", 1056);

    // same block again with random bubbles and backpressure
    send_block(1056, 1'b0, 1'b1, 99999, 1055);
    recv_block(1056, 1'b1);
    compare("backpressure_1056", 1056);

    // size select flipped mid-block: length stays at the latched 1056
    send_block(1056, 1'b0, 1'b0, 500, 1055);
    recv_block(1056, 1'b0);
    compare("size_latch_1056", 1056);

    // reset in the middle of DRAIN, then a fresh 1056 block
    send_block(1056, 1'b0, 1'b0, 99999, 1055);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    rst = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("mid_rst_release_ready", in_ready, 1);
    for (int i = 0; i < 1056; i++) orig[i] = ~ref1[i];
    interleave(1056);
    send_block(1056, 1'b0, 1'b0, 99999, 1055);
    recv_block(1056, 1'b0);
    compare("after_reset_1056", 1056);

`ifdef CODER_DEINT_LAST_EN
    check("err_len_clean", err_len, 0);
`endif
    // early in_last at i = 100 flags a length error but the K counter still rules
    send_block(1056, 1'b0, 1'b0, 99999, 100);
    recv_block(1056, 1'b0);
    compare("early_last_1056", 1056);
`ifdef CODER_DEINT_LAST_EN
    check("err_len_set", err_len, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/coder_deinterleaver.md
# coder_deinterleaver

Bit-serial QPP deinterleaver for the turbo coder datapath: the inverse of the coder interleaver. Accepts one interleaved block of K bits (K = 1056 or K = 6144) as a valid/ready stream, writes each bit to its natural-order position pi(i) in an internal 6144 x 1 buffer, then streams the block out in natural order. It sits between the rate-matching/receive path and the turbo decoder input. It handles one block at a time, with no overlap between load and drain.

## Interface
- `K_SMALL`, 1056: short block size; the QPP coefficients are f1 = 17, f2 = 66.
- `K_LARGE`, 6144: long block size; the QPP coefficients are f1 = 263, f2 = 480.
- `AW`, 13: address/counter width; must satisfy 2^AW > K_LARGE.
- `clk`  in  1  the single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `K_eq_6144`  in  1  block size select (1 = 6144, 0 = 1056); sampled only on the first accepted bit of a block.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  1  interleaved bit, with i = arrival order.
- `in_ready`  out  1  the block can accept a bit.
- `out_valid`  out  1  `out_data` is valid.
- `out_data`  out  1  deinterleaved bit, with j = output order.
- `out_ready`  in  1  the downstream consumer takes the bit.
- `busy`  out  1  high from the first accepted input bit until the last output bit is taken.

## Operation
- Mapping: pi(i) = (f1*i + f2*i^2) mod K, and mem[pi(i)] <= in_data(i). Output j is mem[j] for j = 0..K-1.
- Address generation is recursive, with no multipliers:
  - pi(0) = 0 and g(0) = (f1+f2) mod K.
  - pi(i+1) = (pi(i)+g(i)) mod K.
  - g(i+1) = (g(i) + 2*f2) mod K.
  - Each mod is a single conditional subtract of K, because both operands are < K.
  - Seed values: g(0) = 83 with step 132 for K = 1056; g(0) = 743 with step 960 for K = 6144.
- FSM states: LOAD, TURN, DRAIN.
- LOAD:
  - `in_ready` = 1.
  - On each accept (`in_valid & in_ready`), write mem[pi], advance pi and g, and increment `cnt`.
  - On the accept with cnt == 0, latch `K_eq_6144` into `ksel`. `ksel` is held until the block completes, so changes on `K_eq_6144` mid-block are ignored.
  - On the accept with cnt == K-1, go to TURN and clear `cnt`.
- TURN: a single cycle, `in_ready` = 0. It issues the read of mem[0], then goes to DRAIN.
- DRAIN:
  - `in_ready` = 0.
  - A one-entry output register sits behind the synchronous-read buffer. The read address advances only when the register is empty or is being consumed (`out_valid & out_ready`).
  - After the handshake for j = K-1, clear pi, g, `cnt` and `out_valid`, then go to LOAD.
- Simultaneous events: `in_valid` asserted during TURN or DRAIN is not accepted. Holding `out_ready` low stalls the output indefinitely with `out_data` stable.
- Reset mid-operation: the partial block is discarded. The buffer contents are not cleared; they are don't-care because every location is rewritten by the next block.

## Timing
- Reset values: `in_ready` = 0 during reset and 1 from the first cycle after `rst` deasserts (state LOAD). `out_valid` = 0, `out_data` = 0, `busy` = 0. `cnt`, pi, g and `ksel` are all 0.
- Input throughput is 1 bit/clock with no bubbles.
- Latency: the accept of the last input bit is at cycle t; TURN is at t+1; the first `out_valid` is at t+2.
- With `out_ready` held at 1, output is 1 bit/clock. The last output handshake is at t+K+1, and `in_ready` = 1 again at t+K+2.
- `out_valid` and `out_data` change only after a handshake or a load from the buffer; they never drop without a handshake.

## Configuration
- `CODER_DEINT_LAST_EN`:
  - When defined, the block adds an output port `out_last` (1 bit) that is high with `out_valid` exactly for j = K-1. It also adds an input port `in_last`. An `in_last` asserted on an accept where cnt != K-1 sets a sticky `err_len` output, which is cleared by `rst`. The block is still governed by the K counter.
  - When undefined, these ports are absent and no length check is performed.

## Test plan
- Reset: hold `rst` for 3 cycles -> `in_ready` = `out_valid` = `busy` = 0 during reset; `in_ready` = 1 on the first cycle after reset.
- K = 1056 single one: input bit i = 1 is 1, all others 0 -> the only 1 out is at j = 83; the first `out_valid` comes 2 cycles after the last accept.
- K = 6144 address check: send single ones at i = 1, 2, 3 in three separate blocks -> outputs at j = 743, 2446 and 5109 respectively.
- Round trip: random 6144-bit and 1056-bit blocks pass through a model of the coder interleaver and then this block -> the output equals the original input, checked bit for bit.
- Backpressure: random `in_valid` and `out_ready` toggling at 50% -> the same data as the no-stall run, with no lost or duplicated bits and `out_data` stable while stalled.
- Size latch and reset: toggle `K_eq_6144` mid-block -> the block length stays as latched. Assert `rst` mid-DRAIN -> the next 1056 block is correct. With `CODER_DEINT_LAST_EN` defined, `in_last` at i = 100 -> `err_len` = 1.
